trivium_keygen_ctrl: RTL
========================

Name: trivium_keygen_ctrl

Overview:
Sequencer for the Trivium keystream core in the entropy-to-key path.
- Collects 160 raw ADC entropy bits as the key and IV seed.
- Loads the core and runs the standard warm-up, discarding keystream.
- Streams keystream bits into two KEY_WIDTH registers, p then q, and presents them to the requester.
- Sits between the ADC sampler and the key consumer, and drives the external Trivium core through a load/enable/keystream interface.

Parameters:
KEY_WIDTH, 128, width of each of the p and q output words (sourced from params).
SEED_KEY_BITS, 80, Trivium key length.
SEED_IV_BITS, 80, Trivium IV length.
WARMUP_CYCLES, 1152, core_en cycles with output discarded after load (4*288).

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
adc_in  in  1  raw entropy bit
adc_wr  in  1  adc_in valid this cycle
req  in  1  level request for a new p/q pair
p  out  KEY_WIDTH  first generated word
q  out  KEY_WIDTH  second generated word
valid  out  1  p/q complete and stable
busy  out  1  high in LOAD, WARMUP, GEN_P, GEN_Q
seed_full  out  1  all 160 seed bits captured
core_load  out  1  one-cycle load strobe to the core
core_key  out  SEED_KEY_BITS  key to the core, seed[159:80]
core_iv  out  SEED_IV_BITS  IV to the core, seed[79:0]
core_en  out  1  advance the core one step
core_z  in  1  core keystream bit, valid in any cycle core_en=1

Behaviour:
- Reset (rst=0, async): state=COLLECT, seed=0, seed count=0, step counter=0. All outputs are 0, including p, q, valid, busy and seed_full.
- COLLECT:
  - On adc_wr=1 with count<160: seed <= {seed[158:0], adc_in}; count++. The first bit captured ends at seed[159].
  - seed_full = (count==160). adc_wr is ignored when full and in every other state.
  - Leave for LOAD on an edge where req=1 and seed_full=1. That edge is the acceptance edge.
  - If req=1 before the seed is full, wait in COLLECT.
- LOAD: exactly 1 cycle with core_load=1 and core_en=0. core_key and core_iv are driven continuously from seed.
- WARMUP: core_en=1 for exactly WARMUP_CYCLES cycles; core_z is ignored.
- GEN_P: core_en=1 for KEY_WIDTH cycles; each cycle p <= {p[KEY_WIDTH-2:0], core_z}. The first keystream bit ends at the p MSB.
- GEN_Q: identical to GEN_P, filling q.
- DONE:
  - valid=1 and busy=0; p and q are held.
  - Stay while req=1. On the first edge with req=0: valid<=0, seed count<=0, return to COLLECT.
  - A fresh seed is required for every pair. p and q keep their values until the next GEN_P overwrites them.
- Latency: valid rises exactly 1+WARMUP_CYCLES+2*KEY_WIDTH edges after the acceptance edge.
- Boundary conditions:
  - req dropping between LOAD and GEN_Q is ignored: the sequence completes, then DONE exits on the next edge, giving a one-cycle valid pulse.
  - adc_wr in the same cycle as acceptance is not captured.
  - Reset mid-sequence aborts immediately. core_en and core_load go low asynchronously and all state is lost.
  - The step counter is sized for max(WARMUP_CYCLES, KEY_WIDTH) and clears on each state entry.
- core_en is never high together with core_load.

Optional Feature:
Macro TRIVIUM_KEYGEN_PRIME_FIX_EN.
- Defined: on the final GEN_P cycle the stored p has bit KEY_WIDTH-1 and bit 0 forced to 1; the same applies to q on the final GEN_Q cycle. The result is odd, full-width RSA prime candidates.
- Undefined: p and q are the raw keystream.
- Latency is identical in both builds.

Decomposition:
- params package: KEY_WIDTH, SEED_KEY_BITS, SEED_IV_BITS, WARMUP_CYCLES.
- le_types package: enum trivium_keygen_state_t {COLLECT, LOAD, WARMUP, GEN_P, GEN_Q, DONE}.
- One sub-module, entropy_seed_sr: the 160-bit shift register plus counter, with ports clk, rst, adc_in, adc_wr, clr, seed, full.
- The FSM, counter and p/q shifters stay in the top.

Test Plan:
- Seed load: drive 160 adc_wr bits alternating 1,0,…, starting with 1, with req=0. Expect seed_full=1, core_key=80'hAAAA_AAAA_AAAA_AAAA_AAAA, core_iv the same, and state held in COLLECT.
- Full sequence, core_z stub tied to 1, KEY_WIDTH=128, req=1. Expect:
  - core_load high exactly 1 cycle;
  - core_en high exactly 1152+256 cycles;
  - valid rises 1409 edges after acceptance;
  - p=q=all ones.
- Ordering, core_z stub = 1 on the first keystream cycle after warm-up and 0 afterwards. Expect p=128'h8000…0 and q=0 without the macro; with TRIVIUM_KEYGEN_PRIME_FIX_EN, p=128'h8000…1 and q=128'h8000…1.
- Early request: req=1 after only 100 seed bits. Expect no core_load until the 160th adc_wr; acceptance on that following edge.
- req drops at cycle 50 of WARMUP. Expect the sequence to complete, valid high for exactly 1 cycle, return to COLLECT with seed_full=0, and p/q retained.
- rst asserted mid-GEN_P. Expect core_en=0 and p=q=0 immediately; after release, state COLLECT and seed_full=0.

Source files
------------

// File: rtl/trivium_keygen_ctrl_pkg.sv
// Shared parameters, state encoding and word helpers for the Trivium
// key-generation sequencer.
// Optional feature macro: TRIVIUM_KEYGEN_PRIME_FIX_EN (odd, full-width p/q).
package trivium_keygen_ctrl_pkg;

   localparam int KEY_WIDTH     = 128;
   localparam int SEED_KEY_BITS = 80;
   localparam int SEED_IV_BITS  = 80;
   localparam int WARMUP_CYCLES = 1152;

   localparam int SEED_BITS  = SEED_KEY_BITS + SEED_IV_BITS;
   localparam int SEED_CNT_W = $clog2(SEED_BITS + 1);
   localparam int STEP_MAX   = (WARMUP_CYCLES > KEY_WIDTH) ? WARMUP_CYCLES : KEY_WIDTH;
   localparam int STEP_W     = $clog2(STEP_MAX);

   typedef enum logic [2:0] {
      COLLECT,
      LOAD,
      WARMUP,
      GEN_P,
      GEN_Q,
      DONE
   } trivium_keygen_state_t;

   // Force the top and bottom bits so the word is an odd, full-width candidate.
   function automatic logic [KEY_WIDTH-1:0] prime_fix(input logic [KEY_WIDTH-1:0] w);
      logic [KEY_WIDTH-1:0] r;
      r = w;
      r[KEY_WIDTH-1] = 1'b1;
      r[0]           = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/trivium_keygen_ctrl_entropy_seed_sr.sv
// 160-bit entropy seed shift register with fill counter.
// The first captured bit ends up in the MSB once the register is full.
// clr only rewinds the fill counter; the old bits are shifted out by the
// next fill, so nothing stale reaches the core once full is set again.
module entropy_seed_sr
   import trivium_keygen_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 adc_in,
   input  logic                 adc_wr,
   input  logic                 clr,
   output logic [SEED_BITS-1:0] seed,
   output logic                 full
);

   logic [SEED_CNT_W-1:0] count;

   assign full = (count == SEED_CNT_W'(SEED_BITS));

   // Shift in entropy bits until full; writes while full are dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seed  <= '0;
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (adc_wr && !full) begin
         seed  <= {seed[SEED_BITS-2:0], adc_in};
         count <= count + SEED_CNT_W'(1);
      end
   end

endmodule

// File: rtl/trivium_keygen_ctrl.sv
// Trivium key-generation sequencer: collects an entropy seed, loads and
// warms up the external Trivium core, then shifts keystream into p and q.
// Optional feature macro: TRIVIUM_KEYGEN_PRIME_FIX_EN forces bit MSB and
// bit 0 of p and q to 1 on their final fill cycle; latency is unchanged.
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | capture adc bits into the seed; wait for req with full seed
// LOAD    | one-cycle core_load strobe, core not advanced
// WARMUP  | core_en for WARMUP_CYCLES, keystream discarded
// GEN_P   | core_en for KEY_WIDTH cycles, keystream shifted into p
// GEN_Q   | core_en for KEY_WIDTH cycles, keystream shifted into q
// DONE    | valid; hold p/q until req drops, then rewind the seed
module trivium_keygen_ctrl
   import trivium_keygen_ctrl_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     adc_in,
   input  logic                     adc_wr,
   input  logic                     req,
   output logic [KEY_WIDTH-1:0]     p,
   output logic [KEY_WIDTH-1:0]     q,
   output logic                     valid,
   output logic                     busy,
   output logic                     seed_full,
   output logic                     core_load,
   output logic [SEED_KEY_BITS-1:0] core_key,
   output logic [SEED_IV_BITS-1:0]  core_iv,
   output logic                     core_en,
   input  logic                     core_z
);

   trivium_keygen_state_t state, state_nxt;
   logic [STEP_W-1:0]     step;
   logic                  step_tc;
   logic [SEED_BITS-1:0]  seed;
   logic                  seed_wr;
   logic                  seed_clr;
   logic [KEY_WIDTH-1:0]  p_shift;
   logic [KEY_WIDTH-1:0]  q_shift;

   assign step_tc  = (step == '0);
   assign seed_wr  = adc_wr && (state == COLLECT);
   assign seed_clr = (state == DONE) && !req;

   assign core_key = seed[SEED_BITS-1 -: SEED_KEY_BITS];
   assign core_iv  = seed[SEED_IV_BITS-1:0];

   entropy_seed_sr u_seed (
      .clk    (clk),
      .rst    (rst),
      .adc_in (adc_in),
      .adc_wr (seed_wr),
      .clr    (seed_clr),
      .seed   (seed),
      .full   (seed_full)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= COLLECT;
      else      state <= state_nxt;
   end

   // Next-state decode; phase lengths come from the step down-counter.
   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: if (req && seed_full) state_nxt = LOAD;
         LOAD:                          state_nxt = WARMUP;
         WARMUP:  if (step_tc)          state_nxt = GEN_P;
         GEN_P:   if (step_tc)          state_nxt = GEN_Q;
         GEN_Q:   if (step_tc)          state_nxt = DONE;
         DONE:    if (!req)             state_nxt = COLLECT;
         default:                       state_nxt = COLLECT;
      endcase
   end

   // Output decode; everything is a pure function of state so reset clears it at once.
   always_comb begin
      core_load = 1'b0;
      core_en   = 1'b0;
      busy      = 1'b0;
      valid     = 1'b0;
      case (state)
         LOAD: begin
            core_load = 1'b1;
            busy      = 1'b1;
         end
         WARMUP, GEN_P, GEN_Q: begin
            core_en = 1'b1;
            busy    = 1'b1;
         end
         DONE:    valid = 1'b1;
         default: ;
      endcase
   end

   // Step down-counter: reloaded on every state change, terminal count at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         step <= '0;
      end else if (state_nxt != state) begin
         case (state_nxt)
            WARMUP:       step <= STEP_W'(WARMUP_CYCLES - 1);
            GEN_P, GEN_Q: step <= STEP_W'(KEY_WIDTH - 1);
            default:      step <= '0;
         endcase
      end else if (!step_tc) begin
         step <= step - STEP_W'(1);
      end
   end

   // Next shifter values, with the odd/full-width fixup on the last fill cycle.
   always_comb begin
      p_shift = {p[KEY_WIDTH-2:0], core_z};
      q_shift = {q[KEY_WIDTH-2:0], core_z};
`ifdef TRIVIUM_KEYGEN_PRIME_FIX_EN
      if (step_tc) begin
         p_shift = prime_fix(p_shift);
         q_shift = prime_fix(q_shift);
      end
`endif
   end

   // p fills MSB-first during GEN_P and holds otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                p <= '0;
      else if (state == GEN_P) p <= p_shift;
   end

   // q fills MSB-first during GEN_Q and holds otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                q <= '0;
      else if (state == GEN_Q) q <= q_shift;
   end

endmodule
